// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Start is sampled only in IDLE. A normal divide produces a one-cycle done
// pulse WIDTH clocks after the accepted start. Divide-by-zero takes a
// single-cycle FIN path instead. Results are held until the next done.
// Optional feature macro: DIV_SIGNED_EN (two's complement operands/results).
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q;    // partial remainder
  logic [WIDTH-1:0] dq_q;     // dividend shifts out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;    // captured divisor magnitude
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quo_q, rmd_q;
`ifdef DIV_SIGNED_EN
  logic             negq_q;   // operand signs differ
  logic             negr_q;   // dividend was negative
`endif

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_d, dq_d;
  logic [WIDTH-1:0] quo_d, rmd_d, zrem_d;

  // Operand magnitudes at capture; identity in the unsigned build
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
`ifdef DIV_SIGNED_EN
    if (dividend[WIDTH-1]) dvd_mag = -dividend;
    if (divisor[WIDTH-1])  dvs_mag = -divisor;
`endif
  end

  // One restoring iteration: shift, trial subtract at WIDTH+1 bits, restore on borrow
  always_comb begin
    shifted = {rem_q, dq_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      dq_d  = {dq_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted[WIDTH-1:0];
      dq_d  = {dq_q[WIDTH-2:0], 1'b0};
    end
  end

  // Result sign fix-up in the done cycle; zrem_d rebuilds the raw dividend
  always_comb begin
    quo_d  = dq_d;
    rmd_d  = rem_d;
    zrem_d = dq_q;
`ifdef DIV_SIGNED_EN
    if (negq_q) quo_d  = -dq_d;
    if (negr_q) rmd_d  = -rem_d;
    if (negr_q) zrem_d = -dq_q;
`endif
  end

  // Control FSM with registered outputs; reset wins over start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
`ifdef DIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q   <= '0;
            dq_q    <= dvd_mag;
            dvs_q   <= dvs_mag;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            negq_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            negr_q  <= dividend[WIDTH-1];
`endif
            state_q <= (divisor == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          dq_q  <= dq_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        FIN: begin
          quo_q   <= '1;
          rmd_q   <= zrem_d;
          dbz_q   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule
